// File: rtl/mem_bus_decoder.sv
// Registered memory-map decoder and bus sequencer: decodes a CPU request
// against per-region base/mask pairs, strobes one device for a cycle,
// inserts per-region wait states, returns read data and flags unmapped
// accesses with a sticky flag and a latched error address.
module mem_bus_decoder #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int REGIONS = 4,
   parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = {16'hD000, 16'hE000, 16'h0800, 16'h0000},
   parameter logic [REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFFF0, 16'hE000, 16'hF800, 16'hF800},
   parameter logic [REGIONS*4-1:0]      REGION_WAIT = {4'd2, 4'd0, 4'd0, 4'd0},
   parameter logic [DATA_W-1:0]         DEFAULT_DATA = 8'hFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          cpuAddr,
   input  logic                       cpuStrobe,
   input  logic                       cpuWrite,
   input  logic [DATA_W-1:0]          cpuDataWrite,
   output logic [DATA_W-1:0]          cpuDataRead,
   output logic                       cpuReady,
   output logic                       cpuBusy,
   output logic [ADDR_W-1:0]          devAddr,
   output logic [DATA_W-1:0]          devDataWrite,
   output logic                       devWrite,
   output logic [REGIONS-1:0]         devStrobe,
   input  logic [REGIONS*DATA_W-1:0]  devDataRead,
   output logic                       busError,
   output logic                       errorFlag,
   output logic [ADDR_W-1:0]          errorAddr,
   input  logic                       errorClear
);

   localparam int SELW = (REGIONS > 1) ? $clog2(REGIONS) : 1;

   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, CAPTURE, DONE} state_t;

   state_t            state, stateNext;
   logic [SELW-1:0]   sel;
   logic              writeLat;
   logic              mapped;
   logic [3:0]        waitCnt;
   logic              hitAny;
   logic [SELW-1:0]   hitIdx;
   logic [3:0]        selWait;
   logic [DATA_W-1:0] selData;

   // Address decode: lowest-indexed matching region wins.
   always_comb begin
      hitAny = 1'b0;
      hitIdx = '0;
      for (int unsigned i = 0; i < REGIONS; i++) begin
         if (!hitAny &&
             ((cpuAddr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
            hitAny = 1'b1;
            hitIdx = SELW'(i);
         end
      end
   end

   // Per-region wait count and read data for the latched region.
   always_comb begin
      selWait = '0;
      selData = '0;
      for (int unsigned i = 0; i < REGIONS; i++) begin
         if (sel == SELW'(i)) begin
            selWait = REGION_WAIT[i*4 +: 4];
            selData = devDataRead[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Next-state logic and state-decoded bus outputs.
   always_comb begin
      stateNext = state;
      devStrobe = '0;
      devWrite  = 1'b0;
      cpuReady  = 1'b0;
      busError  = 1'b0;
      cpuBusy   = (state != IDLE);
      case (state)
         IDLE: begin
            if (cpuStrobe) stateNext = hitAny ? ACCESS : DONE;
         end
         ACCESS: begin
            for (int unsigned i = 0; i < REGIONS; i++)
               devStrobe[i] = (sel == SELW'(i));
            devWrite  = writeLat;
            stateNext = (selWait != 4'd0) ? WAIT : CAPTURE;
         end
         WAIT: begin
            if (waitCnt == 4'd1) stateNext = CAPTURE;
         end
         CAPTURE: stateNext = DONE;
         DONE: begin
            cpuReady  = 1'b1;
            busError  = !mapped;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Request latching, wait counting and read-data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         devAddr      <= '0;
         devDataWrite <= '0;
         cpuDataRead  <= '0;
         errorAddr    <= '0;
         writeLat     <= 1'b0;
         mapped       <= 1'b0;
         sel          <= '0;
         waitCnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpuStrobe) begin
                  devAddr      <= cpuAddr;
                  devDataWrite <= cpuDataWrite;
                  writeLat     <= cpuWrite;
                  sel          <= hitIdx;
                  mapped       <= hitAny;
                  if (!hitAny) begin
                     cpuDataRead <= DEFAULT_DATA;
                     errorAddr   <= cpuAddr;
                  end
               end
            end
            ACCESS:  waitCnt <= selWait;
            WAIT:    waitCnt <= waitCnt - 4'd1;
            CAPTURE: if (!writeLat) cpuDataRead <= selData;
            default: ;
         endcase
      end
   end

   // Sticky error flag; a new unmapped capture takes priority over clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         errorFlag <= 1'b0;
      else if (state == IDLE && cpuStrobe && !hitAny)
         errorFlag <= 1'b1;
      else if (errorClear)
         errorFlag <= 1'b0;
   end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Self-checking bench for mem_bus_decoder: a scoreboard queue holds the
// expected completion of each request and is drained on cpuReady.
module tb_mem_bus_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpuAddr;
   logic        cpuStrobe;
   logic        cpuWrite;
   logic [7:0]  cpuDataWrite;
   logic [7:0]  cpuDataRead;
   logic        cpuReady;
   logic        cpuBusy;
   logic [15:0] devAddr;
   logic [7:0]  devDataWrite;
   logic        devWrite;
   logic [3:0]  devStrobe;
   logic [31:0] devDataRead;
   logic        busError;
   logic        errorFlag;
   logic [15:0] errorAddr;
   logic        errorClear;

   // outputs of the priority-override instance
   logic [7:0]  cpuDataReadP;
   logic        cpuReadyP, cpuBusyP, devWriteP, busErrorP, errorFlagP;
   logic [15:0] devAddrP, errorAddrP;
   logic [7:0]  devDataWriteP;
   logic [3:0]  devStrobeP;

   int assertCount = 0;
   int failCount   = 0;
   int cycleCnt    = 0;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         reqCycle;
      int         lat;
   } exp_t;

   exp_t sbQ[$];
   exp_t item;

   logic [7:0] devMem [4] = '{8'hA5, 8'h11, 8'h22, 8'h5A};
   logic [7:0] devReg [4] = '{default: 8'h00};
   logic [7:0] wrMem  [4] = '{default: 8'h00};

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   mem_bus_decoder dut (
      .clk(clk), .reset(reset), .cpuAddr(cpuAddr), .cpuStrobe(cpuStrobe),
      .cpuWrite(cpuWrite), .cpuDataWrite(cpuDataWrite), .cpuDataRead(cpuDataRead),
      .cpuReady(cpuReady), .cpuBusy(cpuBusy), .devAddr(devAddr),
      .devDataWrite(devDataWrite), .devWrite(devWrite), .devStrobe(devStrobe),
      .devDataRead(devDataRead), .busError(busError), .errorFlag(errorFlag),
      .errorAddr(errorAddr), .errorClear(errorClear)
   );

   mem_bus_decoder #(
      .REGION_BASE({16'hD000, 16'hE000, 16'h0000, 16'h0000}),
      .REGION_MASK({16'hFFF0, 16'hE000, 16'hF000, 16'hF800})
   ) dutP (
      .clk(clk), .reset(reset), .cpuAddr(cpuAddr), .cpuStrobe(cpuStrobe),
      .cpuWrite(cpuWrite), .cpuDataWrite(cpuDataWrite), .cpuDataRead(cpuDataReadP),
      .cpuReady(cpuReadyP), .cpuBusy(cpuBusyP), .devAddr(devAddrP),
      .devDataWrite(devDataWriteP), .devWrite(devWriteP), .devStrobe(devStrobeP),
      .devDataRead(devDataRead), .busError(busErrorP), .errorFlag(errorFlagP),
      .errorAddr(errorAddrP), .errorClear(errorClear)
   );

   // Device model: read data appears one cycle after the strobe and holds.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (devStrobe[i]) begin
            if (devWrite) wrMem[i]  <= devDataWrite;
            else          devReg[i] <= devMem[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) devDataRead[i*8 +: 8] = devReg[i];
   end

   task automatic checkValue(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("FAIL %s: got %h expected %h at cycle %0d", tag, actual, expected, cycleCnt);
      end
   endtask

   // Completion monitor: every cpuReady must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && cpuReady) begin
         if (sbQ.size() == 0) begin
            checkValue("spuriousReady", 32'd1, 32'd0);
         end else begin
            item = sbQ.pop_front();
            checkValue("readData", {24'd0, cpuDataRead}, {24'd0, item.data});
            checkValue("busError", {31'd0, busError}, {31'd0, item.err});
            checkValue("readyLatency", cycleCnt - item.reqCycle, item.lat);
         end
      end
   end

   task automatic doRequest(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                            input logic [3:0] expStrobe, input logic [3:0] expStrobeP,
                            input logic [7:0] expData, input logic expErr, input int lat,
                            input logic clr);
      @(negedge clk);
      cpuAddr = addr; cpuWrite = wr; cpuDataWrite = wdata; cpuStrobe = 1'b1; errorClear = clr;
      sbQ.push_back('{data: expData, err: expErr, reqCycle: cycleCnt, lat: lat});
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            // scramble inputs so the latched copies are what gets checked
            cpuStrobe = 1'b0; errorClear = 1'b0; cpuAddr = ~addr; cpuDataWrite = ~wdata;
         end
         checkValue("devStrobe", {28'd0, devStrobe}, (k == 1) ? {28'd0, expStrobe} : 32'd0);
         checkValue("devStrobeP", {28'd0, devStrobeP}, (k == 1) ? {28'd0, expStrobeP} : 32'd0);
         checkValue("devWrite", {31'd0, devWrite}, {31'd0, (k == 1) && wr && !expErr});
         checkValue("cpuBusy", {31'd0, cpuBusy}, {31'd0, k <= lat});
         if (!expErr) begin
            checkValue("devAddr", {16'd0, devAddr}, {16'd0, addr});
            if (wr) checkValue("devDataWrite", {24'd0, devDataWrite}, {24'd0, wdata});
         end
      end
      for (int t = 0; t < 20 && sbQ.size() != 0; t++) @(negedge clk);
      if (sbQ.size() != 0) begin
         checkValue("readyTimeout", sbQ.size(), 32'd0);
         sbQ.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cpuAddr = '0; cpuStrobe = 1'b0; cpuWrite = 1'b0;
      cpuDataWrite = '0; errorClear = 1'b0;
      repeat (3) @(negedge clk);
      checkValue("rstDataRead", {24'd0, cpuDataRead}, 32'd0);
      checkValue("rstDevAddr", {16'd0, devAddr}, 32'd0);
      checkValue("rstStrobe", {28'd0, devStrobe}, 32'd0);
      checkValue("rstBusy", {31'd0, cpuBusy}, 32'd0);
      checkValue("rstErrFlag", {31'd0, errorFlag}, 32'd0);
      checkValue("rstErrAddr", {16'd0, errorAddr}, 32'd0);
      reset = 1'b0;

      // region 0 read, no wait states
      doRequest(16'h0123, 1'b0, 8'h00, 4'b0001, 4'b0001, 8'hA5, 1'b0, 3, 1'b0);
      checkValue("devAddrHold", {16'd0, devAddr}, 32'h0123);
      // region 3 read, two wait states
      doRequest(16'hD004, 1'b0, 8'h00, 4'b1000, 4'b1000, 8'h5A, 1'b0, 5, 1'b0);
      // region 2 write: read data holds previous value
      doRequest(16'hE010, 1'b1, 8'h3C, 4'b0100, 4'b0100, 8'h5A, 1'b0, 3, 1'b0);
      checkValue("devWriteData", {24'd0, wrMem[2]}, 32'h3C);
      checkValue("devDataWriteHold", {24'd0, devDataWrite}, 32'h3C);
      // unmapped read
      doRequest(16'h4000, 1'b0, 8'h00, 4'b0000, 4'b0000, 8'hFF, 1'b1, 1, 1'b0);
      checkValue("errFlagSet", {31'd0, errorFlag}, 32'd1);
      checkValue("errAddr", {16'd0, errorAddr}, 32'h4000);
      // region 1 read; error flag stays sticky
      doRequest(16'h0810, 1'b0, 8'h00, 4'b0010, 4'b0010, 8'h11, 1'b0, 3, 1'b0);
      checkValue("errFlagSticky", {31'd0, errorFlag}, 32'd1);
      // unmapped with simultaneous clear: set wins
      doRequest(16'h4100, 1'b0, 8'h00, 4'b0000, 4'b0000, 8'hFF, 1'b1, 1, 1'b1);
      checkValue("errSetWins", {31'd0, errorFlag}, 32'd1);
      checkValue("errAddr2", {16'd0, errorAddr}, 32'h4100);
      @(negedge clk); errorClear = 1'b1;
      @(negedge clk); errorClear = 1'b0;
      checkValue("errCleared", {31'd0, errorFlag}, 32'd0);
      // overlapping regions in the override instance: region 0 wins
      doRequest(16'h0400, 1'b0, 8'h00, 4'b0001, 4'b0001, 8'hA5, 1'b0, 3, 1'b0);

      // reset in the middle of a wait-state read
      @(negedge clk);
      cpuAddr = 16'hD004; cpuWrite = 1'b0; cpuStrobe = 1'b1;
      @(negedge clk);
      cpuStrobe = 1'b0;
      checkValue("abortAccessStrobe", {28'd0, devStrobe}, 32'h8);
      @(negedge clk);
      checkValue("abortInWait", {31'd0, cpuBusy}, 32'd1);
      reset = 1'b1;
      #1;
      checkValue("abortBusy", {31'd0, cpuBusy}, 32'd0);
      checkValue("abortStrobe", {28'd0, devStrobe}, 32'd0);
      checkValue("abortDevAddr", {16'd0, devAddr}, 32'd0);
      checkValue("abortDataRead", {24'd0, cpuDataRead}, 32'd0);
      checkValue("abortErrAddr", {16'd0, errorAddr}, 32'd0);
      checkValue("abortReady", {31'd0, cpuReady}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         checkValue("abortIdle", {31'd0, cpuBusy}, 32'd0);
      end
      // normal operation after the abort
      doRequest(16'h0123, 1'b0, 8'h00, 4'b0001, 4'b0001, 8'hA5, 1'b0, 3, 1'b0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
